alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that borrows the execute-stage
// ALU one operation per cycle and returns the low DATA_WIDTH bits of a*b.
module alu_mul_sequencer #(
  parameter int              DATA_WIDTH = 32,
  parameter logic [3:0]      OP_ADD     = 4'b0000,
  parameter logic [3:0]      OP_SLL     = 4'b1100,
  parameter logic [3:0]      OP_SRL     = 4'b0011
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] Multiplicand_i,
  input  logic [DATA_WIDTH-1:0] Multiplier_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] Product_o,
  output logic [3:0]            ALU_Operation_o,
  output logic [DATA_WIDTH-1:0] ALU_A_o,
  output logic [DATA_WIDTH-1:0] ALU_B_o,
  input  logic [DATA_WIDTH-1:0] ALU_Result_i,
  input  logic                  ALU_Zero_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EVAL = 3'd1;
  localparam logic [2:0] S_ADD  = 3'd2;
  localparam logic [2:0] S_SRL  = 3'd3;
  localparam logic [2:0] S_SHL  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_prod;

  // Sequencer state and datapath registers; each ALU step commits on the
  // edge that closes its cycle, and the product latches on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= ZERO;
      r_mplier <= ZERO;
      r_acc    <= ZERO;
      r_prod   <= ZERO;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mcand  <= Multiplicand_i;
            r_mplier <= Multiplier_i;
            r_acc    <= ZERO;
            r_prod   <= ZERO;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_mplier == ZERO) begin
            r_prod  <= r_acc;
            r_state <= S_DONE;
          end else if (r_mplier[0]) begin
            r_state <= S_ADD;
          end else begin
            r_state <= S_SRL;
          end
        end
        S_ADD: begin
          r_acc   <= ALU_Result_i;
          r_state <= S_SRL;
        end
        S_SRL: begin
          r_mplier <= ALU_Result_i;
          if (ALU_Zero_i) begin
            r_prod  <= r_acc;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SHL;
          end
        end
        S_SHL: begin
          r_mcand <= ALU_Result_i;
          r_state <= S_EVAL;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU port drive: idle default (ADD 0,0) outside the three ALU steps.
  always_comb begin
    ALU_Operation_o = OP_ADD;
    ALU_A_o         = ZERO;
    ALU_B_o         = ZERO;
    unique case (r_state)
      S_ADD: begin
        ALU_Operation_o = OP_ADD;
        ALU_A_o         = r_acc;
        ALU_B_o         = r_mcand;
      end
      S_SRL: begin
        ALU_Operation_o = OP_SRL;
        ALU_A_o         = r_mplier;
        ALU_B_o         = ONE;
      end
      S_SHL: begin
        ALU_Operation_o = OP_SLL;
        ALU_A_o         = r_mcand;
        ALU_B_o         = ONE;
      end
      default: begin
        ALU_Operation_o = OP_ADD;
      end
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy_o    = (r_state != S_IDLE);
    done_o    = (r_state == S_DONE);
    Product_o = r_prod;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench with a behavioural ALU and a
// plain-arithmetic product/latency model.
module tb_alu_mul_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b0011;

  logic        clk = 0;
  logic        reset = 1;
  logic        start_i = 0;
  logic [31:0] mcand_i = 0;
  logic [31:0] mplier_i = 0;
  logic        busy_o, done_o;
  logic [31:0] prod_o;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;

  alu_mul_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .Multiplicand_i  (mcand_i),
    .Multiplier_i    (mplier_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .Product_o       (prod_o),
    .ALU_Operation_o (alu_op),
    .ALU_A_o         (alu_a),
    .ALU_B_o         (alu_b),
    .ALU_Result_i    (alu_res),
    .ALU_Zero_i      (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SLL:  alu_res = alu_a << alu_b[4:0];
      OP_SRL:  alu_res = alu_a >> alu_b[4:0];
      default: alu_res = 32'h0;
    endcase
    alu_zero = (alu_res == 32'h0);
  end

  typedef struct {
    logic [31:0] prod;
    int          e0;
    int          dn;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  trace[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          prev_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int latency(input logic [31:0] b);
    int k, p;
    if (b == 0) return 1;
    k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    p = $countones(b);
    return 3 * k + 2 + p;
  endfunction

  // Monitor: pops the scoreboard on done_o and checks port behaviour.
  always @(negedge clk) begin
    if (!reset) begin
      bit exp_busy;
      exp_busy = (q.size() > 0) && (cyc >= q[0].e0) && (cyc <= q[0].dn);
      chk(busy_o == exp_busy, "busy", 32'(busy_o), 32'(exp_busy));
      if (!busy_o || done_o) begin
        chk(alu_op == OP_ADD && alu_a == 0 && alu_b == 0, "alu_idle",
            alu_a | alu_b | 32'(alu_op), 32'h0);
      end else begin
        if (alu_op == OP_SRL || alu_op == OP_SLL)
          chk(alu_b == 32'd1, "shift_by_1", alu_b, 32'd1);
        else
          chk(alu_op == OP_ADD, "alu_opcode", 32'(alu_op), 32'(OP_ADD));
        if (!(alu_op == OP_ADD && alu_a == 0 && alu_b == 0))
          trace.push_back(alu_op);
      end
      if (done_o) begin
        chk(!prev_done, "done_pulse", 32'(prev_done), 32'h0);
        if (q.size() == 0) begin
          chk(0, "spurious_done", 32'h1, 32'h0);
        end else begin
          chk(prod_o == q[0].prod, "product", prod_o, q[0].prod);
          chk(cyc == q[0].dn, "latency", 32'(cyc), 32'(q[0].dn));
          void'(q.pop_front());
        end
      end
    end
    prev_done <= done_o;
  end

  // Stimulus helpers
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk); #1;
    mcand_i = a;
    mplier_i = b;
    start_i = 1;
    e.prod = a * b;
    e.e0 = cyc + 1;
    e.dn = cyc + 1 + latency(b);
    q.push_back(e);
  endtask

  task automatic wait_idle(input bit drop_start);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      if (drop_start) start_i = 0;
      n++;
    end
    if (q.size() != 0) begin
      chk(0, "timeout", 32'(n), 32'h0);
      q.delete();
    end
    start_i = 0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    @(negedge clk); #1;
    start_i = 0;
    mcand_i = $urandom;
    mplier_i = $urandom;
    wait_idle(1);
  endtask

  initial begin
    logic [3:0] exp_tr[$];
    logic [63:0] m;
    repeat (2) @(negedge clk);
    chk(busy_o == 0 && done_o == 0 && prod_o == 0, "reset_state",
        prod_o | 32'(busy_o) | 32'(done_o), 32'h0);
    chk(alu_op == OP_ADD && alu_a == 0 && alu_b == 0, "reset_alu",
        alu_a | alu_b | 32'(alu_op), 32'h0);
    #1 reset = 0;

    // 5 x 3 with op trace
    trace.delete();
    run(32'd5, 32'd3);
    exp_tr = '{OP_ADD, OP_SRL, OP_SLL, OP_ADD, OP_SRL};
    chk(trace == exp_tr, "trace_5x3", 32'(trace.size()), 32'd5);

    // multiplier zero: no ALU activity
    trace.delete();
    run(32'h1234, 32'h0);
    chk(trace.size() == 0, "trace_x0", 32'(trace.size()), 32'h0);

    run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32'h0001_0000, 32'h0001_0000);

    // start held while busy, operands changed at E0+2
    issue(32'd7, 32'd6);
    @(negedge clk); #1;
    @(negedge clk); #1;
    mcand_i = 32'd9;
    mplier_i = 32'd9;
    wait_idle(0);
    repeat (3) @(negedge clk);
    run(32'd9, 32'd9);

    // async reset mid-operation
    issue(32'hFF, 32'hFF);
    @(negedge clk); #1;
    start_i = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    q.delete();
    #1;
    chk(busy_o == 0 && done_o == 0 && prod_o == 0, "async_reset",
        prod_o | 32'(busy_o) | 32'(done_o), 32'h0);
    chk(alu_op == OP_ADD && alu_a == 0 && alu_b == 0, "async_reset_alu",
        alu_a | alu_b | 32'(alu_op), 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    run(32'd2, 32'd2);

    // random regression
    for (int i = 0; i < 400; i++) begin
      m = (64'd1 << $urandom_range(32, 0)) - 64'd1;
      run($urandom, $urandom & m[31:0]);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
